// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_ctrl
//  Brief    : Owns every write to the 64-bit HI/LO register. Runs MULT/MULTU
//             (MUL_LAT cycles), DIV/DIVU (32-step restoring divide plus a
//             sign-fix cycle) and MTHI/MTLO. Stalls EX while busy, then
//             issues one registered write strobe with {HI,LO} data.
//  Options  : HILO_FWD_EN - adds the hilo_fwd output and makes MTHI/MTLO
//             merge with the forwarded value instead of hilo_cur.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic [63:0] hilo_cur,
  output logic        stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        div_zero
`ifdef HILO_FWD_EN
  ,
  output logic [63:0] hilo_fwd
`endif
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_FIX  = 2'd3;

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam logic [4:0] c_MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] c_DIV_LAST = 5'd31;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [4:0]         r_cnt;
  logic signed [32:0] r_mul_a;
  logic signed [32:0] r_mul_b;
  logic [31:0]        r_quo;
  logic [31:0]        r_rem;
  logic [31:0]        r_dvs;
  logic               r_qneg;
  logic               r_rneg;

  logic               w_idle_req;
  logic               w_mul_go;
  logic               w_div_go;
  logic               w_div_zero;
  logic               w_mt_go;
  logic               w_is_mul;
  logic               w_is_div;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic signed [63:0] w_prod;
  logic [32:0]        w_shift;
  logic [32:0]        w_diff;
  logic               w_ge;
  logic [31:0]        w_quo_fix;
  logic [31:0]        w_rem_fix;
  logic [63:0]        w_merge_src;

  // Request decode: only an unflushed start seen in IDLE can be accepted.
  assign w_idle_req = (r_state == c_IDLE) && start && !flush;
  assign w_is_mul   = (op == c_OP_MULT) || (op == c_OP_MULTU);
  assign w_is_div   = (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign w_mul_go   = w_idle_req && w_is_mul;
  assign w_div_go   = w_idle_req && w_is_div && (b != 32'd0);
  assign w_div_zero = w_idle_req && w_is_div && (b == 32'd0);
  assign w_mt_go    = w_idle_req && ((op == c_OP_MTHI) || (op == c_OP_MTLO));

  // Signed divide runs on magnitudes; signs are restored in FIX.
  assign w_a_mag = ((op == c_OP_DIV) && a[31]) ? (-a) : a;
  assign w_b_mag = ((op == c_OP_DIV) && b[31]) ? (-b) : b;

  // 33x33 signed multiply covers both MULT (sign-extended) and MULTU (zero-extended).
  assign w_prod = 64'(r_mul_a) * 64'(r_mul_b);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = !w_diff[32];

  assign w_quo_fix = r_qneg ? (-r_quo) : r_quo;
  assign w_rem_fix = r_rneg ? (-r_rem) : r_rem;

`ifdef HILO_FWD_EN
  assign hilo_fwd    = hilo_we ? hilo_wdata : hilo_cur;
  assign w_merge_src = hilo_fwd;
`else
  assign w_merge_src = hilo_cur;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_mul_go)      w_next_state = c_MUL;
          else if (w_div_go) w_next_state = c_DIV;
        end
        c_MUL:   if (r_cnt == c_MUL_LAST) w_next_state = c_IDLE;
        c_DIV:   if (r_cnt == c_DIV_LAST) w_next_state = c_FIX;
        default: w_next_state = c_IDLE;
      endcase
    end
  end

  // Stall output: busy states, or a multi-cycle op being accepted this cycle.
  always_comb begin
    stall = 1'b0;
    if (!flush) stall = (r_state != c_IDLE) || w_mul_go || w_div_go;
  end

  // Iteration counter and operand/partial-result datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 5'd0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else if (flush) begin
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_cnt <= 5'd0;
          if (w_mul_go) begin
            r_mul_a <= {(op == c_OP_MULT) & a[31], a};
            r_mul_b <= {(op == c_OP_MULT) & b[31], b};
          end
          if (w_div_go) begin
            r_quo  <= w_a_mag;
            r_dvs  <= w_b_mag;
            r_rem  <= 32'd0;
            r_qneg <= (op == c_OP_DIV) & (a[31] ^ b[31]);
            r_rneg <= (op == c_OP_DIV) & a[31];
          end
        end
        c_MUL: r_cnt <= (r_cnt == c_MUL_LAST) ? 5'd0 : r_cnt + 5'd1;
        c_DIV: begin
          r_cnt <= r_cnt + 5'd1;
          r_quo <= {r_quo[30:0], w_ge};
          r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
        end
        default: r_cnt <= 5'd0;
      endcase
    end
  end

  // Registered result strobes; a flush suppresses any result not yet registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_we    <= 1'b0;
      hilo_wdata <= 64'd0;
      div_zero   <= 1'b0;
    end else begin
      hilo_we  <= 1'b0;
      div_zero <= 1'b0;
      if (!flush) begin
        if (w_mt_go) begin
          hilo_we    <= 1'b1;
          hilo_wdata <= (op == c_OP_MTHI) ? {a, w_merge_src[31:0]}
                                          : {w_merge_src[63:32], a};
        end
        if (w_div_zero) div_zero <= 1'b1;
        if ((r_state == c_MUL) && (r_cnt == c_MUL_LAST)) begin
          hilo_we    <= 1'b1;
          hilo_wdata <= w_prod;
        end
        if (r_state == c_FIX) begin
          hilo_we    <= 1'b1;
          hilo_wdata <= {w_rem_fix, w_quo_fix};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencer that owns all writes to the 64-bit HI/LO register.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs a multi-cycle multiply or a 32-iteration restoring divide.
- Stalls the pipeline while busy, then issues a single registered write strobe plus 64-bit data to the HI/LO register, which samples on negedge.
- Sits between the EX stage and the HI/LO register.

Parameters:
- MUL_LAT, 2, multiply latency in cycles; legal range 1..8.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  op request valid; sampled only in IDLE.
- op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- a  in  32  rs operand / MTHI/MTLO source.
- b  in  32  rt operand.
- flush  in  1  exception flush; aborts any op.
- hilo_cur  in  64  current HI/LO contents, {HI,LO}.
- stall  out  1  hold the EX instruction; combinational.
- hilo_we  out  1  registered one-cycle write strobe to the HI/LO register.
- hilo_wdata  out  64  registered {HI,LO} write data.
- div_zero  out  1  registered one-cycle pulse; divide by zero detected.

Behaviour:
- Reset: state=IDLE, counter=0, hilo_we=0, hilo_wdata=0, div_zero=0. Reset has priority over flush and start.
- States: IDLE, MUL, DIV, FIX.
- hilo_we and div_zero default to 0 every cycle. Each is 1 for exactly one cycle per completed op.
- Start is accepted only when state=IDLE, start=1, flush=0 and op is 1..6. Starts in any other state are ignored; the requester is stalled, so none can arrive.
- Cycle T below is the accept cycle.

MTHI/MTLO:
- No state change and no stall.
- At T+1: hilo_we=1, hilo_wdata={a, hilo_cur[31:0]} for MTHI, or {hilo_cur[63:32], a} for MTLO.

MULT/MULTU:
- Operands latched at T; MUL occupies T+1..T+MUL_LAT.
- Product is a 64-bit signed (MULT) or unsigned (MULTU) product.
- At T+MUL_LAT+1: hilo_we=1 with the product; state returns to IDLE.
- stall=1 for T..T+MUL_LAT.

DIV/DIVU with b≠0:
- At T, latch magnitudes: for DIV, take abs of operands as 32-bit unsigned values; for DIVU, use raw values. Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (DIV only).
- DIV occupies T+1..T+32, one restoring iteration per cycle (33-bit partial remainder); the counter counts 0..31.
- FIX at T+33: negate the quotient and/or remainder per the latched signs.
- At T+34: hilo_we=1, hilo_wdata={remainder, quotient}; state=IDLE.
- stall=1 for T..T+33.
- 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0 through natural 32-bit truncation; no special case.

DIV/DIVU with b=0:
- No state change, no stall, no HI/LO write.
- div_zero=1 at T+1.

stall (combinational):
- 1 when state∈{MUL,DIV,FIX}, or when state=IDLE, start=1, op∈{1,2}, flush=0, or op∈{3,4} with b≠0 under the same conditions.
- Forced to 0 whenever flush=1.

flush:
- In any state, the next state is IDLE and the counter is cleared.
- An in-flight result is discarded: no hilo_we is issued for an op flushed at or before its FIX/last-MUL cycle.
- A hilo_we already registered (high in the flush cycle) is not retracted.
- A start in the same cycle as flush is dropped.

Back-to-back ops:
- A new start is legal in the cycle hilo_we is high (state is IDLE).
- An MTHI/MTLO in that cycle merges with hilo_cur, not with the in-flight hilo_wdata, unless HILO_FWD_EN is defined.

Optional Feature:
- HILO_FWD_EN defined:
  - Adds output hilo_fwd[63:0] = hilo_we ? hilo_wdata : hilo_cur, for EX-stage MFHI/MFLO forwarding.
  - MTHI/MTLO merges use hilo_fwd instead of hilo_cur.
- Not defined: no hilo_fwd port; merges use hilo_cur only.

Test Plan:
- MULT a=0xFFFFFFFE, b=3, MUL_LAT=2 -> stall high T..T+2; hilo_we at T+3 with 0xFFFFFFFF_FFFFFFFA.
- MULTU with the same operands -> hilo_we at T+3 with 0x00000002_FFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall T..T+33; hilo_we only at T+34 with 0xFFFFFFFF_FFFFFFFD.
- DIVU a=100, b=7 -> 0x00000002_0000000E at T+34. DIVU with b=0 -> no stall, no hilo_we, div_zero pulse at T+1.
- MTHI a=0x12345678, hilo_cur=0xAAAAAAAA_BBBBBBBB -> hilo_we at T+1 with 0x12345678_BBBBBBBB, stall never high. MTLO -> 0xAAAAAAAA_12345678.
- DIV started at T, flush at T+10 -> stall 0 at T+10, state IDLE at T+11, no hilo_we through T+40. rst at T+5 of a MULT -> all outputs 0 next cycle, no write.
